// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch core: FSM state encoding, BCD digit geometry
// and the centisecond/second moduli used to build the digit cascade.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } sw_state_e;

  localparam int unsigned NIBBLE_W   = 4;
  localparam int unsigned NUM_DIGITS = 6;
  localparam int unsigned DIGITS_W   = NIBBLE_W * NUM_DIGITS;

  localparam int unsigned DEC_MOD   = 10;
  localparam int unsigned CS_MOD    = 100;
  localparam int unsigned SEC_MOD   = 60;
  localparam int unsigned CS_T_MOD  = CS_MOD / DEC_MOD;
  localparam int unsigned SEC_T_MOD = SEC_MOD / DEC_MOD;

  function automatic logic [NIBBLE_W-1:0] to_nibble(input int unsigned v);
    return NIBBLE_W'(v);
  endfunction

endpackage

// File: rtl/stopwatch_bcd_digit.sv
// One BCD digit of the stopwatch cascade: counts 0..MODULUS-1 when enabled,
// synchronous clear has priority, carry asserts on the enabled wrap cycle.
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter int unsigned MODULUS = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                clr,
  output logic [NIBBLE_W-1:0] value,
  output logic                carry
);

  localparam logic [NIBBLE_W-1:0] TOP = to_nibble(MODULUS - 1);

  logic [NIBBLE_W-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (en) begin
      value_d = (value_q == TOP) ? '0 : value_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;
  assign carry = en & (value_q == TOP);

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch core: start/stop/clear FSM driving a six-digit BCD mm:ss.cc cascade.
// Define STOPWATCH_LAP_EN to add the lap-hold display capture.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int unsigned MINUTE_LIMIT    = 59,
  parameter int unsigned STICKY_OVERFLOW = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic                btn_ss,
  input  logic                btn_clr,
  input  logic                btn_lap,
  output logic [DIGITS_W-1:0] digits,
  output logic                running,
  output logic                paused,
  output logic                ovf
);

  localparam logic [NIBBLE_W-1:0] MIN_T_MAX = to_nibble(MINUTE_LIMIT / DEC_MOD);
  localparam logic [NIBBLE_W-1:0] MIN_U_MAX = to_nibble(MINUTE_LIMIT % DEC_MOD);
  localparam logic [NIBBLE_W-1:0] SEC_T_MAX = to_nibble(SEC_T_MOD - 1);
  localparam logic [NIBBLE_W-1:0] CS_T_MAX  = to_nibble(CS_T_MOD - 1);
  localparam logic [NIBBLE_W-1:0] DEC_MAX   = to_nibble(DEC_MOD - 1);
  localparam logic                STICKY    = (STICKY_OVERFLOW != 0);

  sw_state_e state_q, state_d;
  logic ss_prev_q, clr_prev_q;
  logic running_q, running_d, paused_q, paused_d, ovf_q, ovf_d;
  logic ss_edge, clr_edge, clr_to_idle, adv, at_max, ovf_evt, cnt_en, digit_clr;
  logic [NIBBLE_W-1:0] cs_u, cs_t, sec_u, sec_t, min_u, min_t;
  logic cs_u_co, cs_t_co, sec_u_co, sec_t_co, min_u_co, unused_min_t_co;
  logic [DIGITS_W-1:0] live;

  assign ss_edge     = btn_ss & ~ss_prev_q;
  assign clr_edge    = btn_clr & ~clr_prev_q;
  assign clr_to_idle = clr_edge & (state_q != ST_RUN);
  assign adv         = tick & (state_q == ST_RUN);

  assign at_max = (min_t == MIN_T_MAX) && (min_u == MIN_U_MAX) &&
                  (sec_t == SEC_T_MAX) && (sec_u == DEC_MAX) &&
                  (cs_t == CS_T_MAX) && (cs_u == DEC_MAX);
  assign ovf_evt = adv & at_max;

  // Sticky mode freezes the cascade at the limit; wrap mode clears it on the same edge.
  assign cnt_en    = adv & ~(STICKY & at_max);
  assign digit_clr = clr_to_idle | (ovf_evt & ~STICKY);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!clr_edge && ss_edge) state_d = ST_RUN;
      ST_RUN:   if (ss_edge) state_d = ST_PAUSE;
      ST_PAUSE: begin
        if (clr_edge)     state_d = ST_IDLE;
        else if (ss_edge) state_d = ST_RUN;
      end
      default:  state_d = ST_IDLE;
    endcase
    running_d = (state_d == ST_RUN);
    paused_d  = (state_d == ST_PAUSE);
    if (clr_to_idle) ovf_d = 1'b0;
    else if (STICKY) ovf_d = ovf_q | ovf_evt;
    else             ovf_d = ovf_evt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      ss_prev_q  <= 1'b0;
      clr_prev_q <= 1'b0;
      running_q  <= 1'b0;
      paused_q   <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ss_prev_q  <= btn_ss;
      clr_prev_q <= btn_clr;
      running_q  <= running_d;
      paused_q   <= paused_d;
      ovf_q      <= ovf_d;
    end
  end

  bcd_digit #(.MODULUS(DEC_MOD)) u_cs_u (
    .clk(clk), .rst(rst), .en(cnt_en), .clr(digit_clr), .value(cs_u), .carry(cs_u_co)
  );
  bcd_digit #(.MODULUS(CS_T_MOD)) u_cs_t (
    .clk(clk), .rst(rst), .en(cs_u_co), .clr(digit_clr), .value(cs_t), .carry(cs_t_co)
  );
  bcd_digit #(.MODULUS(DEC_MOD)) u_sec_u (
    .clk(clk), .rst(rst), .en(cs_t_co), .clr(digit_clr), .value(sec_u), .carry(sec_u_co)
  );
  bcd_digit #(.MODULUS(SEC_T_MOD)) u_sec_t (
    .clk(clk), .rst(rst), .en(sec_u_co), .clr(digit_clr), .value(sec_t), .carry(sec_t_co)
  );
  // Minutes never carry past MINUTE_LIMIT: reaching it ends in the overflow path above.
  bcd_digit #(.MODULUS(DEC_MOD)) u_min_u (
    .clk(clk), .rst(rst), .en(sec_t_co), .clr(digit_clr), .value(min_u), .carry(min_u_co)
  );
  bcd_digit #(.MODULUS(MINUTE_LIMIT / DEC_MOD + 1)) u_min_t (
    .clk(clk), .rst(rst), .en(min_u_co), .clr(digit_clr), .value(min_t), .carry(unused_min_t_co)
  );

  assign live    = {min_t, min_u, sec_t, sec_u, cs_t, cs_u};
  assign running = running_q;
  assign paused  = paused_q;
  assign ovf     = ovf_q;

`ifdef STOPWATCH_LAP_EN
  logic lap_prev_q, lap_hold_q, lap_hold_d, lap_edge;
  logic [DIGITS_W-1:0] lap_val_q, lap_val_d;

  assign lap_edge = btn_lap & ~lap_prev_q;

  // The captured lap value is the live count as displayed just before the toggle edge.
  always_comb begin
    lap_hold_d = lap_hold_q;
    lap_val_d  = lap_val_q;
    if (clr_to_idle) begin
      lap_hold_d = 1'b0;
    end else if (lap_edge && (state_q != ST_IDLE)) begin
      lap_hold_d = ~lap_hold_q;
      if (!lap_hold_q) lap_val_d = live;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lap_prev_q <= 1'b0;
      lap_hold_q <= 1'b0;
      lap_val_q  <= '0;
    end else begin
      lap_prev_q <= btn_lap;
      lap_hold_q <= lap_hold_d;
      lap_val_q  <= lap_val_d;
    end
  end

  assign digits = lap_hold_q ? lap_val_q : live;
`else
  logic unused_lap;
  assign unused_lap = btn_lap;
  assign digits     = live;
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core: a sticky (MINUTE_LIMIT=1) and a wrapping (MINUTE_LIMIT=10) instance
// share one stimulus stream and are compared against a centisecond-count reference model.
module tb_stopwatch_core;

  localparam int unsigned LIM_A = 1;
  localparam int unsigned LIM_B = 10;
  localparam int MODEL_IDLE  = 0;
  localparam int MODEL_RUN   = 1;
  localparam int MODEL_PAUSE = 2;

  logic clk = 1'b0;
  logic rst, tick, btnSs, btnClr, btnLap;
  logic [23:0] digitsA, digitsB;
  logic runningA, pausedA, ovfA, runningB, pausedB, ovfB;

  always #5 clk = ~clk;

  stopwatch_core #(.MINUTE_LIMIT(LIM_A), .STICKY_OVERFLOW(1)) dutSticky (
    .clk(clk), .rst(rst), .tick(tick), .btn_ss(btnSs), .btn_clr(btnClr), .btn_lap(btnLap),
    .digits(digitsA), .running(runningA), .paused(pausedA), .ovf(ovfA)
  );

  stopwatch_core #(.MINUTE_LIMIT(LIM_B), .STICKY_OVERFLOW(0)) dutWrap (
    .clk(clk), .rst(rst), .tick(tick), .btn_ss(btnSs), .btn_clr(btnClr), .btn_lap(btnLap),
    .digits(digitsB), .running(runningB), .paused(pausedB), .ovf(ovfB)
  );

  int checks = 0;
  int failures = 0;

  int mState[2];
  int mCount[2];
  int mLap[2];
  int mMax[2];
  bit mOvf[2];
  bit mHold[2];
  bit mSticky[2];
  bit pSs, pClr, pLap;

  function automatic logic [23:0] toBcd(input int cs);
    int mins, secs, cents;
    mins  = cs / 6000;
    secs  = (cs / 100) % 60;
    cents = cs % 100;
    return {4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10),
            4'(cents / 10), 4'(cents % 10)};
  endfunction

  function automatic logic [23:0] expDigits(input int k);
    return toBcd(mHold[k] ? mLap[k] : mCount[k]);
  endfunction

  task automatic modelReset();
    mMax[0] = (LIM_A * 60 + 59) * 100 + 99;
    mMax[1] = (LIM_B * 60 + 59) * 100 + 99;
    mSticky[0] = 1'b1;
    mSticky[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mState[k] = MODEL_IDLE;
      mCount[k] = 0;
      mLap[k]   = 0;
      mOvf[k]   = 1'b0;
      mHold[k]  = 1'b0;
    end
    pSs = 1'b0;
    pClr = 1'b0;
    pLap = 1'b0;
  endtask

  task automatic modelStep(input bit ss, input bit clr, input bit lap, input bit tk);
    bit ssE, clrE, lapE, clrIdle, adv;
    ssE  = ss & ~pSs;
    clrE = clr & ~pClr;
    lapE = lap & ~pLap;
    pSs  = ss;
    pClr = clr;
    pLap = lap;
    for (int k = 0; k < 2; k++) begin
      clrIdle = clrE && (mState[k] != MODEL_RUN);
      adv     = tk && (mState[k] == MODEL_RUN);
      if (clrIdle) begin
        mCount[k] = 0;
        mOvf[k]   = 1'b0;
        mHold[k]  = 1'b0;
      end else begin
        if (lapE && mState[k] != MODEL_IDLE) begin
`ifdef STOPWATCH_LAP_EN
          if (!mHold[k]) mLap[k] = mCount[k];
          mHold[k] = !mHold[k];
`else
          mHold[k] = 1'b0;
`endif
        end
        if (adv && mCount[k] == mMax[k]) begin
          mOvf[k] = 1'b1;
          if (!mSticky[k]) mCount[k] = 0;
        end else begin
          if (adv) mCount[k] = mCount[k] + 1;
          if (!mSticky[k]) mOvf[k] = 1'b0;
        end
      end
      case (mState[k])
        MODEL_IDLE:  if (!clrE && ssE) mState[k] = MODEL_RUN;
        MODEL_RUN:   if (ssE) mState[k] = MODEL_PAUSE;
        default: begin
          if (clrE)     mState[k] = MODEL_IDLE;
          else if (ssE) mState[k] = MODEL_RUN;
        end
      endcase
    end
  endtask

  task automatic cmpVec(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cmpBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    cmpVec({tag, "/A.digits"},  digitsA,  expDigits(0));
    cmpBit({tag, "/A.running"}, runningA, mState[0] == MODEL_RUN);
    cmpBit({tag, "/A.paused"},  pausedA,  mState[0] == MODEL_PAUSE);
    cmpBit({tag, "/A.ovf"},     ovfA,     mOvf[0]);
    cmpVec({tag, "/B.digits"},  digitsB,  expDigits(1));
    cmpBit({tag, "/B.running"}, runningB, mState[1] == MODEL_RUN);
    cmpBit({tag, "/B.paused"},  pausedB,  mState[1] == MODEL_PAUSE);
    cmpBit({tag, "/B.ovf"},     ovfB,     mOvf[1]);
  endtask

  task automatic applyStimulus(input bit ss, input bit clr, input bit lap, input bit tk);
    btnSs  = ss;
    btnClr = clr;
    btnLap = lap;
    tick   = tk;
    @(posedge clk);
    modelStep(ss, clr, lap, tk);
    #1;
  endtask

  task automatic goIdle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    if (mState[0] == MODEL_RUN) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("go_idle");
  endtask

  task automatic runTicks(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b0;
    tick = 1'b0;
    btnSs = 1'b0;
    btnClr = 1'b0;
    btnLap = 1'b0;
    modelReset();
    #12;
    checkOutput("reset");
    @(negedge clk);
    #1 rst = 1'b1;

    // Start and count 150 ticks.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("ss_start");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    runTicks(150);
    checkOutput("run150");
    cmpVec("run150.anchor", digitsA, 24'h000150);
    cmpBit("run150.running", runningA, 1'b1);

    // Randomized mix of buttons and ticks.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 15) == 0, $urandom_range(0, 39) == 0,
                    $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1);
      checkOutput("random");
    end

    // Stop edge coincident with a carry-producing tick.
    goIdle();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    runTicks(99);
    checkOutput("at099");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("stop_tick");
    cmpVec("stop_tick.anchor", digitsA, 24'h000100);
    cmpBit("stop_tick.paused", pausedA, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    runTicks(20);
    checkOutput("pause_ticks");
    cmpVec("pause_ticks.anchor", digitsA, 24'h000100);

    // Clear ignored in RUN, then simultaneous ss+clr in RUN and in PAUSE.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    runTicks(200);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("clr_in_run");
    cmpBit("clr_in_run.running", runningA, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    runTicks(199);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("ssclr_run");
    cmpVec("ssclr_run.anchor", digitsA, 24'h000500);
    cmpBit("ssclr_run.paused", pausedA, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("ssclr_pause");
    cmpVec("ssclr_pause.anchor", digitsA, 24'h000000);
    cmpBit("ssclr_pause.running", runningA, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

`ifdef STOPWATCH_LAP_EN
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("lap_idle");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    runTicks(200);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    runTicks(300);
    checkOutput("lap_hold");
    cmpVec("lap_hold.anchor", digitsA, 24'h000200);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("lap_release");
    cmpVec("lap_release.anchor", digitsA, 24'h000500);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    goIdle();
`endif

    // Asynchronous reset mid-RUN, with start/stop held through release.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    runTicks(37);
    btnSs = 1'b1;
    #2 rst = 1'b0;
    modelReset();
    #1;
    checkOutput("async_rst");
    cmpVec("async_rst.digits", digitsA, 24'h000000);
    cmpBit("async_rst.running", runningA, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("held_after_rst");
    cmpBit("held_after_rst.running", runningA, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("held_no_second_edge");
    cmpVec("held_no_second_edge.digits", digitsA, 24'h000001);

    // Long run through both overflow points.
    goIdle();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 66005; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      if ((i % 500 == 0) || (i >= 11997 && i <= 12003) || (i >= 65997 && i <= 66003))
        checkOutput("long_run");
      if (i == 12000) begin
        cmpVec("sticky_ovf.digits", digitsA, 24'h015999);
        cmpBit("sticky_ovf.ovf", ovfA, 1'b1);
      end
      if (i == 66000) begin
        cmpVec("wrap_ovf.digits", digitsB, 24'h000000);
        cmpBit("wrap_ovf.ovf", ovfB, 1'b1);
      end
      if (i == 66001) begin
        cmpBit("wrap_ovf.pulse_end", ovfB, 1'b0);
        cmpBit("sticky_ovf.held", ovfA, 1'b1);
      end
    end
    goIdle();
    cmpBit("ovf_cleared", ovfA, 1'b0);
    cmpVec("ovf_cleared.digits", digitsA, 24'h000000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
